// File: rtl/lc3_pkg.sv
// Shared types and widths for the LC-3 memory responder.
//   WORD_W      - data word width
//   CNT_W       - latency counter width (LATENCY up to 15)
//   mem_state_t - responder FSM states
package lc3_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_t;

endpackage

// File: rtl/lc3_mem_array.sv
// Word storage for the LC-3 memory responder: 2^ADDR_W x WORD_W.
//   clk     - write clock
//   we      - synchronous write enable
//   waddr   - write word index
//   wdata   - write data
//   raddr   - read word index
//   rdata_c - asynchronous read data (array contents before this edge's write)
// Contents are not reset.
module lc3_mem_array
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Single synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read port
  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 datapath (MAR/MDR interface).
// Captures a one-cycle request, waits LATENCY cycles, then performs the
// access and pulses mem_ready for one cycle. Includes a backdoor preload
// port and a sticky protocol-error flag for requests made while busy.
//   clk, rst             - clock, asynchronous active-high reset
//   addr, data_in        - access address / write data (captured at request)
//   mem_en, mem_we       - request strobe and direction (1 = write)
//   data_out             - last read data
//   mem_ready            - one-cycle completion pulse
//   busy                 - request outstanding
//   init_we/addr/data    - backdoor write port
//   proto_err            - sticky: mem_en seen while busy
module lc3_mem_responder
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic [15:0]       data_in,
  input  logic              mem_en,
  input  logic              mem_we,
  output logic [15:0]       data_out,
  output logic              mem_ready,
  output logic              busy,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [15:0]       init_data,
  output logic              proto_err
);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] wd_q, wd_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              mem_ready_q, mem_ready_d;
  logic              busy_q, busy_d;
  logic              proto_err_q, proto_err_d;

  logic              in_idle_c;
  logic              enter_resp_c;
  logic [ADDR_W-1:0] acc_a_c;
  logic              acc_we_c;
  logic [WORD_W-1:0] acc_wd_c;
  logic              fn_we_c;
  logic              arr_we_c;
  logic [ADDR_W-1:0] arr_waddr_c;
  logic [WORD_W-1:0] arr_wdata_c;
  logic [WORD_W-1:0] rd_data_c;

  // Upper address bits alias onto the implemented words
  if (ADDR_W < WORD_W) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[WORD_W-1:ADDR_W];
  end

  // Access operands: live inputs on the request edge (LATENCY==1), else captured
  assign in_idle_c    = (state_q == MEM_IDLE);
  assign acc_a_c      = in_idle_c ? addr[ADDR_W-1:0] : a_q;
  assign acc_we_c     = in_idle_c ? mem_we : we_q;
  assign acc_wd_c     = in_idle_c ? data_in : wd_q;
  assign enter_resp_c = (in_idle_c && mem_en && (LATENCY == 1)) ||
                        ((state_q == MEM_WAIT) && (cnt_q == CNT_W'(1)));

  // Functional write has priority over the backdoor port on the same edge
  assign fn_we_c     = enter_resp_c && acc_we_c;
  assign arr_we_c    = fn_we_c || init_we;
  assign arr_waddr_c = fn_we_c ? acc_a_c : init_addr;
  assign arr_wdata_c = fn_we_c ? acc_wd_c : init_data;

  lc3_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we      (arr_we_c),
    .waddr   (arr_waddr_c),
    .wdata   (arr_wdata_c),
    .raddr   (acc_a_c),
    .rdata_c (rd_data_c)
  );

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    we_d        = we_q;
    wd_d        = wd_q;
    data_out_d  = data_out_q;
    mem_ready_d = 1'b0;
    busy_d      = 1'b0;
    proto_err_d = proto_err_q;

    case (state_q)
      MEM_IDLE: begin
        if (mem_en) begin
          a_d   = addr[ADDR_W-1:0];
          we_d  = mem_we;
          wd_d  = data_in;
          cnt_d = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? MEM_RESP : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_en) proto_err_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MEM_RESP;
      end
      MEM_RESP: begin
        if (mem_en) proto_err_d = 1'b1;
        state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase

    // Array is sampled before this edge's write lands
    if (enter_resp_c) begin
      mem_ready_d = 1'b1;
      if (!acc_we_c) data_out_d = rd_data_c;
    end

    busy_d = (state_d != MEM_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      we_q        <= 1'b0;
      wd_q        <= '0;
      data_out_q  <= '0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      we_q        <= we_d;
      wd_q        <= wd_d;
      data_out_q  <= data_out_d;
      mem_ready_q <= mem_ready_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign mem_ready = mem_ready_q;
  assign busy      = busy_q;
  assign proto_err = proto_err_q;

endmodule
